// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: instruction-fetch initiator. Owns the PC, drives a
// combinational-read instruction memory, and holds one fetched instruction
// in an output slot for decode (valid/ready handshake, branch redirect).
// Optional feature macro: IF_HALT_DETECT_EN (all-ones word halts fetch).
module imem_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  output logic              o_imem_rd,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [DATA_W-1:0] o_inst_data,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_halted
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

`ifdef IF_HALT_DETECT_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_inst_valid;
  logic [DATA_W-1:0]   r_inst_data;
  logic [ADDR_W-1:0]   r_inst_pc;
  logic                w_capture;
  logic                w_transfer;

  // Slot accepts a new word when empty or being drained this cycle;
  // a redirect suppresses the capture so the stale-path word is dropped.
  assign w_capture  = (r_state == S_RUN) && !i_redirect && (!r_inst_valid || i_inst_ready);
  assign w_transfer = r_inst_valid && i_inst_ready;

  assign o_imem_rd    = w_capture;
  assign o_imem_addr  = r_pc;
  assign o_inst_valid = r_inst_valid;
  assign o_inst_data  = r_inst_data;
  assign o_inst_pc    = r_inst_pc;

`ifdef IF_HALT_DETECT_EN
  logic w_halt_hit;
  logic r_halted;
  assign w_halt_hit = w_capture && (i_imem_rdata == {DATA_W{1'b1}});
  assign o_halted   = r_halted;

  // Halt flag: set by capturing an all-ones word, cleared by redirect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_halted <= 1'b0;
    else if (i_redirect) r_halted <= 1'b0;
    else if (w_halt_hit) r_halted <= 1'b1;
  end
`else
  assign o_halted = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: redirect wins from any state; otherwise en gates RUN.
  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect) begin
      w_state_nxt = i_en ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_en) w_state_nxt = S_RUN;
        S_RUN: begin
`ifdef IF_HALT_DETECT_EN
          if (w_halt_hit)  w_state_nxt = S_HALT;
          else
`endif
          if (!i_en)       w_state_nxt = S_IDLE;
        end
`ifdef IF_HALT_DETECT_EN
        S_HALT: w_state_nxt = S_HALT;
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // PC and output slot: redirect flushes, capture loads, lone transfer empties.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= PC_RST;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
    end else if (i_redirect) begin
      r_pc         <= i_redirect_pc;
      r_inst_valid <= 1'b0;
    end else if (w_capture) begin
      r_inst_data  <= i_imem_rdata;
      r_inst_pc    <= r_pc;
      r_inst_valid <= 1'b1;
      r_pc         <= r_pc + 1'b1;
    end else if (w_transfer) begin
      r_inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk, rst_n, en, imem_rd, inst_valid, inst_ready, redirect, halted;
  logic [7:0]  imem_addr, inst_pc, redirect_pc;
  logic [31:0] imem_rdata, inst_data;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  // reference model state (0 idle, 1 running, 2 halted)
  int          m_st;
  int          m_pc;
  bit          m_v;
  logic [31:0] m_d;
  int          m_ipc;
  bit          m_halt;

  imem_fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_imem_rd(imem_rd), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_inst_data(inst_data), .o_inst_pc(inst_pc),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_halted(halted)
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    m_st = 0; m_pc = 0; m_v = 0; m_d = 0; m_ipc = 0; m_halt = 0;
  endtask

  function automatic bit model_cap();
    return (m_st == 1) && !redirect && (!m_v || inst_ready);
  endfunction

  // advance the model one clock using the inputs currently driven
  task automatic model_step();
    bit cap;
    cap = model_cap();
    if (redirect) begin
      m_pc = redirect_pc; m_v = 0; m_halt = 0; m_st = en ? 1 : 0;
    end else begin
      if (cap) begin
        m_d = mem[m_pc]; m_ipc = m_pc; m_v = 1; m_pc = (m_pc + 1) % 256;
      end else if (m_v && inst_ready) begin
        m_v = 0;
      end
      if (m_st == 0 && en) m_st = 1;
      else if (m_st == 1) begin
        if (HALT_EN && cap && m_d == 32'hFFFF_FFFF) begin m_st = 2; m_halt = 1; end
        else if (!en) m_st = 0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", inst_valid); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", inst_data); end
    checks++; if (inst_pc !== 8'h0) begin errors++; $display("FAIL reset_ipc got %0h exp 0", inst_pc); end
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %0b exp 0", imem_rd); end
    checks++; if (imem_addr !== 8'h0) begin errors++; $display("FAIL reset_addr got %0h exp 0", imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
  endtask

  task automatic test_stream();
    do_reset();
    en = 1'b1; inst_ready = 1'b1;
    cyc();
    for (int k = 0; k < 6; k++) begin
      checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL stream_rd k=%0d got %0b exp 1", k, imem_rd); end
      cyc();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 8'(k) || inst_data !== 32'(k * 10)) begin
        errors++; $display("FAIL stream k=%0d got v=%0b pc=%0h d=%0d exp v=1 pc=%0h d=%0d", k, inst_valid, inst_pc, inst_data, k, k * 10);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1; inst_ready = 1'b1;
    repeat (5) cyc();
    checks++; if (inst_pc !== 8'd3 || inst_data !== 32'd30) begin errors++; $display("FAIL stall_pre got pc=%0h d=%0d exp pc=3 d=30", inst_pc, inst_data); end
    inst_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 8'd3 || inst_data !== 32'd30 || imem_rd !== 1'b0 || imem_addr !== 8'd4) begin
        errors++; $display("FAIL stall_hold k=%0d got v=%0b pc=%0h d=%0d rd=%0b addr=%0h exp 1/3/30/0/4", k, inst_valid, inst_pc, inst_data, imem_rd, imem_addr);
      end
      cyc();
    end
    inst_ready = 1'b1;
    #1;
    checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL stall_release_rd got %0b exp 1", imem_rd); end
    cyc();
    checks++; if (inst_pc !== 8'd4 || inst_data !== 32'd40) begin errors++; $display("FAIL stall_next got pc=%0h d=%0d exp pc=4 d=40", inst_pc, inst_data); end
    cyc();
    checks++; if (inst_pc !== 8'd5 || inst_data !== 32'd50) begin errors++; $display("FAIL stall_next2 got pc=%0h d=%0d exp pc=5 d=50", inst_pc, inst_data); end
  endtask

  task automatic test_redirect();
    do_reset();
    en = 1'b1; inst_ready = 1'b1;
    repeat (3) cyc();
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h80;
    #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL redir_rd got %0b exp 0", imem_rd); end
    cyc();
    redirect = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 8'h80) begin errors++; $display("FAIL redir_flush got v=%0b addr=%0h exp v=0 addr=80", inst_valid, imem_addr); end
    inst_ready = 1'b1;
    cyc();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h80 || inst_data !== 32'd1280) begin errors++; $display("FAIL redir_target got v=%0b pc=%0h d=%0d exp 1/80/1280", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [3];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
    do_reset();
    en = 1'b1; inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
    cyc();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[k] || inst_data !== 32'(exp_pc[k]) * 32'd10) begin
        errors++; $display("FAIL wrap k=%0d got v=%0b pc=%0h d=%0d exp pc=%0h d=%0d", k, inst_valid, inst_pc, inst_data, exp_pc[k], 32'(exp_pc[k]) * 10);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; inst_ready = 1'b1;
    repeat (4) cyc();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_rd !== 1'b0 || inst_data !== 32'h0 || imem_addr !== 8'h0) begin
      errors++; $display("FAIL async_rst got v=%0b rd=%0b d=%0h addr=%0h exp 0/0/0/0", inst_valid, imem_rd, inst_data, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h0 || inst_data !== 32'h0) begin errors++; $display("FAIL async_restart got v=%0b pc=%0h d=%0d exp 1/0/0", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_halt();
    mem[5] = 32'hFFFF_FFFF;
    do_reset();
    en = 1'b1; inst_ready = 1'b1;
    repeat (7) cyc();
    checks++; if (inst_pc !== 8'd5 || inst_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL halt_word got pc=%0h d=%0h exp 5/ffffffff", inst_pc, inst_data); end
`ifdef IF_HALT_DETECT_EN
    checks++; if (halted !== 1'b1 || imem_rd !== 1'b0) begin errors++; $display("FAIL halt_state got h=%0b rd=%0b exp 1/0", halted, imem_rd); end
    cyc();
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 8'd6 || imem_rd !== 1'b0) begin errors++; $display("FAIL halt_drain got v=%0b addr=%0h rd=%0b exp 0/6/0", inst_valid, imem_addr, imem_rd); end
    redirect = 1'b1; redirect_pc = 8'h00;
    cyc();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %0b exp 0", halted); end
    cyc();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h0 || inst_data !== 32'h0) begin errors++; $display("FAIL halt_resume got v=%0b pc=%0h d=%0d exp 1/0/0", inst_valid, inst_pc, inst_data); end
`else
    checks++; if (halted !== 1'b0 || imem_rd !== 1'b1) begin errors++; $display("FAIL nohalt_state got h=%0b rd=%0b exp 0/1", halted, imem_rd); end
    cyc();
    checks++; if (inst_pc !== 8'd6 || inst_data !== 32'd60) begin errors++; $display("FAIL nohalt_next got pc=%0h d=%0d exp 6/60", inst_pc, inst_data); end
`endif
    mem[5] = 32'd50;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en          = ($urandom_range(0, 9) != 0);
      inst_ready  = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = 8'($urandom);
      if ($urandom_range(0, 99) == 0) mem[$urandom_range(0, 255)] = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (imem_addr !== 8'(m_pc) || imem_rd !== model_cap() || inst_valid !== m_v ||
          (m_v && (inst_data !== m_d || inst_pc !== 8'(m_ipc))) || halted !== m_halt) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rand c=%0d got addr=%0h rd=%0b v=%0b pc=%0h d=%0h h=%0b exp addr=%0h rd=%0b v=%0b pc=%0h d=%0h h=%0b",
                   c, imem_addr, imem_rd, inst_valid, inst_pc, inst_data, halted,
                   8'(m_pc), model_cap(), m_v, 8'(m_ipc), m_d, m_halt);
      end
      model_step();
      cyc();
    end
    redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 10);
    rst_n = 1'b0; en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_halt();
    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 10);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
